// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared 16:1 single-bit mux.
// Optional forced release after MAX_HOLD owned cycles: define MUX_ARB_TIMEOUT_EN.
module mux_rr_arbiter #(
  parameter int unsigned N_REQ    = 16,
  parameter int unsigned SEL_W    = 4,
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [SEL_W-1:0] sel,
  output logic [N_REQ-1:0] grant,
  output logic             valid,
  output logic             timeout
);

  localparam bit PARAMS_OK = (SEL_W == $clog2(N_REQ)) && (MAX_HOLD >= 2) && (MAX_HOLD <= 255);

  generate
    if (!PARAMS_OK) begin : g_bad_params
      $error("mux_rr_arbiter: illegal parameter combination");
    end
  endgenerate

  typedef enum logic {IDLE, OWN} state_t;

  state_t             state_q;
  logic [SEL_W-1:0]   ptr_q;
  logic [SEL_W-1:0]   sel_q;
  logic [N_REQ-1:0]   grant_q;
  logic               valid_q;

  logic [SEL_W-1:0]   win_d;
  logic [SEL_W-1:0]   cand;
  logic               win_found;
  logic               release_req;

  // First requester found scanning upward from the slot after the last owner.
  always_comb begin
    win_d     = '0;
    cand      = '0;
    win_found = 1'b0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      cand = SEL_W'((32'(ptr_q) + i) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_d     = cand;
      end
    end
  end

  assign release_req = done || !req[sel_q];

`ifdef MUX_ARB_TIMEOUT_EN
  logic [7:0] hold_q;
  logic       timeout_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '1;
      sel_q     <= '0;
      grant_q   <= '0;
      valid_q   <= 1'b0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (win_found) begin
            sel_q   <= win_d;
            grant_q <= N_REQ'(1) << win_d;
            valid_q <= 1'b1;
            hold_q  <= '0;
            state_q <= OWN;
          end
        end
        OWN: begin
          // done wins over an expiring hold counter, so timeout only fires on a true forced release.
          if (release_req || (hold_q == 8'(MAX_HOLD - 1))) begin
            grant_q   <= '0;
            valid_q   <= 1'b0;
            ptr_q     <= sel_q;
            state_q   <= IDLE;
            timeout_q <= !release_req;
          end else begin
            hold_q <= hold_q + 8'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign timeout = timeout_q;
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ptr_q   <= '1;
      sel_q   <= '0;
      grant_q <= '0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            sel_q   <= win_d;
            grant_q <= N_REQ'(1) << win_d;
            valid_q <= 1'b1;
            state_q <= OWN;
          end
        end
        OWN: begin
          if (release_req) begin
            grant_q <= '0;
            valid_q <= 1'b0;
            ptr_q   <= sel_q;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign timeout = 1'b0;
`endif

  assign sel   = sel_q;
  assign grant = grant_q;
  assign valid = valid_q;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Randomized and directed bench for mux_rr_arbiter against a queue-free ownership model.
module tb_mux_rr_arbiter;

  localparam int MAXH = 8;
`ifdef MUX_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [3:0]  sel;
  logic [15:0] grant;
  logic        valid;
  logic        timeout;

  int errors = 0;
  int checks = 0;

  // Reference model: current owner (-1 = nobody), priority pointer, shown select, hold count.
  int m_owner, m_ptr, m_sel, m_hold;
  bit m_to;

  always #5 clk = ~clk;

  mux_rr_arbiter #(.N_REQ(16), .SEL_W(4), .MAX_HOLD(MAXH)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = 15;
    m_sel   = 0;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic [15:0] r, input logic d);
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (r != 16'h0) begin
        for (int k = 1; k <= 16; k++) begin
          int idx;
          idx = (m_ptr + k) % 16;
          if (r[idx]) begin
            m_owner = idx;
            m_sel   = idx;
            m_hold  = 0;
            break;
          end
        end
      end
    end else if (d || !r[m_owner]) begin
      m_ptr   = m_owner;
      m_owner = -1;
    end else if (TO_EN && m_hold == MAXH - 1) begin
      m_ptr   = m_owner;
      m_owner = -1;
      m_to    = 1'b1;
    end else begin
      m_hold++;
    end
  endfunction

  task automatic check_outputs(input string tag);
    check({tag, ".sel"},     32'(sel),     32'(m_sel));
    check({tag, ".grant"},   32'(grant),   (m_owner < 0) ? 32'd0 : (32'd1 << m_owner));
    check({tag, ".valid"},   32'(valid),   32'(m_owner >= 0));
    check({tag, ".timeout"}, 32'(timeout), 32'(m_to));
    check({tag, ".onehot0"}, 32'($onehot0(grant)), 32'd1);
  endtask

  // Inputs change at edge+1 (or later); outputs are sampled at the next edge+1.
  task automatic cycle(input string tag, input logic [15:0] r, input logic d);
    req  = r;
    done = d;
    model_step(r, d);
    @(posedge clk);
    #1;
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outputs(tag);
    rst_n = 1'b1;
  endtask

  initial begin
    int nfair, vlen, to_cnt;
    bit fell;
    logic [15:0] r;
    logic d;

    rst_n = 1'b0;
    req   = 16'hFFFF;
    done  = 1'b0;
    model_reset();
    #12;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    cycle("first", 16'hFFFF, 1'b0);
    check("first_grant", 32'(grant), 32'h0001);
    cycle("rel0", 16'h0000, 1'b1);
    cycle("idle", 16'h0000, 1'b0);

    cycle("req5", 16'h0020, 1'b0);
    check("req5_sel", 32'(sel), 32'd5);
    cycle("done5", 16'h0020, 1'b1);
    check("done5_valid", 32'(valid), 32'd0);
    repeat (3) cycle("hold_idle", 16'h0000, 1'b0);
    check("idle_sel_kept", 32'(sel), 32'd5);

    do_reset("reset2");
    nfair = 0;
    for (int i = 0; i < 34; i++) begin
      cycle("fair", 16'hFFFF, 1'b1);
      if (valid === 1'b1) begin
        check("fair_order", 32'(sel), 32'(nfair % 16));
        nfair++;
      end
    end
    check("fair_count", 32'(nfair), 32'd17);

    cycle("g3", 16'h1008, 1'b0);
    check("g3_sel", 32'(sel), 32'd3);
    cycle("r3", 16'h1008, 1'b1);
    cycle("g12", 16'h1008, 1'b0);
    check("g12_sel", 32'(sel), 32'd12);
    cycle("r12", 16'h1008, 1'b1);
    cycle("g3b", 16'h1008, 1'b0);
    check("g3b_sel", 32'(sel), 32'd3);
    cycle("drop3", 16'h0000, 1'b0);

    cycle("g9", 16'h0200, 1'b0);
    cycle("own9", 16'h0200, 1'b0);
    cycle("drop9", 16'h0000, 1'b0);
    check("drop9_valid", 32'(valid), 32'd0);
    cycle("idle_done", 16'h0000, 1'b1);
    check("idle_done_sel", 32'(sel), 32'd9);
    check("idle_done_grant", 32'(grant), 32'd0);

    do_reset("reset3");
    cycle("g7", 16'h0080, 1'b0);
    vlen = 1; to_cnt = 0; fell = 1'b0;
    for (int i = 0; i < MAXH + 3; i++) begin
      cycle("hold7", 16'h0080, 1'b0);
      if (timeout === 1'b1) to_cnt++;
      if (valid !== 1'b1) fell = 1'b1;
      else if (!fell) vlen++;
    end
`ifdef MUX_ARB_TIMEOUT_EN
    check("hold7_len", 32'(vlen), 32'(MAXH));
    check("hold7_timeouts", 32'(to_cnt), 32'd1);
`else
    check("hold7_unbounded", 32'(fell), 32'd0);
    check("hold7_no_timeout", 32'(to_cnt), 32'd0);
`endif
    cycle("own7", 16'h0080, 1'b0);
    do_reset("reset_mid_own");

    r = 16'h0;
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 3))
        0: r = 16'h0;
        1: r = 16'd1 << $urandom_range(0, 15);
        2: r = 16'($urandom);
        default: r = r & 16'($urandom);
      endcase
      d = ($urandom_range(0, 3) == 0);
      cycle("rand", r, d);
      if (i == 200) do_reset("reset_rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
